// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack instruction-memory boot loader.
package hack_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_WORD_W = 16;
  localparam logic [HACK_WORD_W-1:0] HACK_NOP = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_HOLD,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/hack_program_loader.sv
// Boot sequencer: holds the Hack CPU in reset, streams host words into instruction RAM,
// optionally NOP-fills the tail, then releases the CPU after a fixed hold time.
module hack_program_loader
  import hack_pkg::*;
#(
  parameter int PROG_WORDS  = 32768,
  parameter bit FILL_EN     = 1'b1,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [HACK_WORD_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   imem_we,
  output logic [HACK_ADDR_W-1:0] imem_addr,
  output logic [HACK_WORD_W-1:0] imem_wdata,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   err_overflow,
  output logic [15:0]            word_count
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HACK_ADDR_W-1:0] LAST_ADDR = HACK_ADDR_W'(PROG_WORDS - 1);
  localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  loader_state_t          state;
  logic [HACK_ADDR_W-1:0] ptr;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   accept;

  assign in_ready = (state == ST_LOAD);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      hold_cnt     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      word_count   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (start) begin
            state        <= ST_LOAD;
            ptr          <= '0;
            word_count   <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= in_data;
            word_count <= word_count + 16'd1;
            // ptr saturates at the top address so a full 32K image never wraps to 0
            if (ptr != LAST_ADDR) ptr <= ptr + 1'b1;
            if (in_last) begin
              if (FILL_EN && (ptr != LAST_ADDR)) begin
                state <= ST_FILL;
              end else begin
                state    <= ST_HOLD;
                hold_cnt <= HOLD_LOAD;
              end
            end else if (ptr == LAST_ADDR) begin
              state        <= ST_ERROR;
              busy         <= 1'b0;
              err_overflow <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          imem_we    <= 1'b1;
          imem_addr  <= ptr;
          imem_wdata <= HACK_NOP;
          if (ptr == LAST_ADDR) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_HOLD: begin
          // First HOLD cycle still shows the final write; the CPU stays held HOLD_CYCLES more
          if (hold_cnt == '0) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_program_loader.sv
// Self-checking bench: two loaders (fill on / fill off) share one host stream and are
// compared against an expected write list derived from the program contents.
module tb_hack_program_loader;

  localparam int PW = 8;
  localparam int HC = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] in_data = 16'h0;

  logic [1:0]  in_ready, imem_we, cpu_reset, busy, done, err_overflow;
  logic [14:0] imem_addr [2];
  logic [15:0] imem_wdata [2];
  logic [15:0] word_count [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t         wlog0[$];
  wr_t         wlog1[$];
  int          done_cyc [2];
  int          rel_cyc [2];
  logic [1:0]  done_prev = 2'b00;
  logic [1:0]  crst_prev = 2'b11;

  logic [15:0] prog [PW];
  int          plen;
  int          acc_cyc [PW];

  hack_program_loader #(.PROG_WORDS(PW), .FILL_EN(1'b1), .HOLD_CYCLES(HC)) dut_fill (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready[0]), .imem_we(imem_we[0]), .imem_addr(imem_addr[0]),
    .imem_wdata(imem_wdata[0]), .cpu_reset(cpu_reset[0]), .busy(busy[0]), .done(done[0]),
    .err_overflow(err_overflow[0]), .word_count(word_count[0])
  );

  hack_program_loader #(.PROG_WORDS(PW), .FILL_EN(1'b0), .HOLD_CYCLES(HC)) dut_nofill (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready[1]), .imem_we(imem_we[1]), .imem_addr(imem_addr[1]),
    .imem_wdata(imem_wdata[1]), .cpu_reset(cpu_reset[1]), .busy(busy[1]), .done(done[1]),
    .err_overflow(err_overflow[1]), .word_count(word_count[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/event monitor sampled on the falling edge, tagged with the rising-edge count
  always @(negedge clk) begin
    wr_t w;
    if (imem_we[0]) begin
      w = '{cyc: 32'(cyc), addr: imem_addr[0], data: imem_wdata[0]};
      wlog0.push_back(w);
    end
    if (imem_we[1]) begin
      w = '{cyc: 32'(cyc), addr: imem_addr[1], data: imem_wdata[1]};
      wlog1.push_back(w);
    end
    for (int d = 0; d < 2; d++) begin
      if (done[d] && !done_prev[d]) done_cyc[d] = cyc;
      if (!cpu_reset[d] && crst_prev[d]) rel_cyc[d] = cyc;
    end
    done_prev = done;
    crst_prev = cpu_reset;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_start_cpu_reset", d), 32'(cpu_reset[d]), 32'd1);
      check($sformatf("d%0d_start_done", d), 32'(done[d]), 32'd0);
      check($sformatf("d%0d_start_busy", d), 32'(busy[d]), 32'd1);
      check($sformatf("d%0d_start_err", d), 32'(err_overflow[d]), 32'd0);
      check($sformatf("d%0d_start_wc", d), 32'(word_count[d]), 32'd0);
    end
  endtask

  task automatic send_words(input int gmin, input int gmax, input bit start_on_last);
    for (int i = 0; i < plen; i++) begin
      int n;
      repeat ($urandom_range(gmax, gmin)) step();
      n = 0;
      while (!in_ready[0] && n < 20) begin
        step();
        n++;
      end
      if (n >= 20) check("ready_timeout", 32'(in_ready[0]), 32'd1);
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = (i == plen - 1);
      start    = start_on_last && (i == plen - 1);
      acc_cyc[i] = cyc + 1;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
      in_data  = 16'($urandom);
    end
  endtask

  task automatic check_dut(input int d, input wr_t log[$], input bit fill);
    int exp_n;
    int lw;
    exp_n = fill ? PW : plen;
    check($sformatf("d%0d_nwrites", d), 32'(log.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < log.size(); i++) begin
      logic [15:0] exp_data;
      int          exp_cyc;
      exp_data = (i < plen) ? prog[i] : 16'h0000;
      exp_cyc  = (i < plen) ? acc_cyc[i] : acc_cyc[plen-1] + (i - plen + 1);
      check($sformatf("d%0d_wr%0d_addr", d, i), 32'(log[i].addr), 32'(i));
      check($sformatf("d%0d_wr%0d_data", d, i), 32'(log[i].data), 32'(exp_data));
      check($sformatf("d%0d_wr%0d_cyc", d, i), log[i].cyc, 32'(exp_cyc));
    end
    lw = fill ? acc_cyc[plen-1] + (PW - plen) : acc_cyc[plen-1];
    check($sformatf("d%0d_release_cyc", d), 32'(rel_cyc[d]), 32'(lw + HC + 1));
    check($sformatf("d%0d_done_cyc", d), 32'(done_cyc[d]), 32'(lw + HC + 1));
    check($sformatf("d%0d_word_count", d), 32'(word_count[d]), 32'(plen));
    check($sformatf("d%0d_run_cpu_reset", d), 32'(cpu_reset[d]), 32'd0);
    check($sformatf("d%0d_run_busy", d), 32'(busy[d]), 32'd0);
    check($sformatf("d%0d_run_err", d), 32'(err_overflow[d]), 32'd0);
  endtask

  task automatic load_prog(input int gmin, input int gmax, input bit start_on_last);
    int n;
    wlog0.delete();
    wlog1.delete();
    done_cyc = '{-1, -1};
    rel_cyc  = '{-1, -1};
    pulse_start();
    send_words(gmin, gmax, start_on_last);
    n = 0;
    while (done !== 2'b11 && n < 80) begin
      step();
      n++;
    end
    check("done_wait", 32'(done), 32'd3);
    step();
    check_dut(0, wlog0, 1'b1);
    check_dut(1, wlog1, 1'b0);
  endtask

  initial begin
    int n;
    int n0;
    int n1;

    // Reset held low for three cycles
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_cpu_reset", d), 32'(cpu_reset[d]), 32'd1);
      check($sformatf("d%0d_rst_we", d), 32'(imem_we[d]), 32'd0);
      check($sformatf("d%0d_rst_done", d), 32'(done[d]), 32'd0);
      check($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
      check($sformatf("d%0d_rst_wc", d), 32'(word_count[d]), 32'd0);
      check($sformatf("d%0d_rst_ready", d), 32'(in_ready[d]), 32'd0);
    end
    reset = 1'b1;
    step();

    // Directed program, back-to-back
    plen = 3;
    prog[0] = 16'h0000; prog[1] = 16'hEC10; prog[2] = 16'hE7D8;
    load_prog(0, 0, 1'b0);

    // Valid toggling 1/0 with three random words
    for (int i = 0; i < 3; i++) prog[i] = 16'($urandom);
    load_prog(1, 1, 1'b0);

    // Randomised programs, including full-depth and single-word boundaries
    for (int t = 0; t < 6; t++) begin
      plen = (t == 0) ? PW : (t == 1) ? 1 : int'($urandom_range(PW, 1));
      for (int i = 0; i < plen; i++) prog[i] = 16'($urandom);
      load_prog(0, 2, (t == 2));
    end

    // Overflow: eight words without in_last, ninth is refused
    wlog0.delete();
    wlog1.delete();
    pulse_start();
    for (int i = 0; i < PW; i++) begin
      prog[i] = 16'($urandom);
      in_valid = 1'b1;
      in_data  = prog[i];
      in_last  = 1'b0;
      step();
    end
    in_data = 16'($urandom);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_ovf_ready", d), 32'(in_ready[d]), 32'd0);
      check($sformatf("d%0d_ovf_err", d), 32'(err_overflow[d]), 32'd1);
      check($sformatf("d%0d_ovf_cpu_reset", d), 32'(cpu_reset[d]), 32'd1);
      check($sformatf("d%0d_ovf_done", d), 32'(done[d]), 32'd0);
      check($sformatf("d%0d_ovf_wc", d), 32'(word_count[d]), 32'(PW));
    end
    repeat (3) step();
    in_valid = 1'b0;
    step();
    check("d0_ovf_nwrites", 32'(wlog0.size()), 32'(PW));
    check("d1_ovf_nwrites", 32'(wlog1.size()), 32'(PW));
    for (int i = 0; i < PW && i < wlog0.size() && i < wlog1.size(); i++) begin
      check($sformatf("ovf_wr%0d_addr", i), 32'(wlog0[i].addr), 32'(i));
      check($sformatf("ovf_wr%0d_data", i), 32'(wlog1[i].data), 32'(prog[i]));
    end
    check("d0_ovf_err_held", 32'(err_overflow[0]), 32'd1);

    // start out of ERROR, then a reload from RUN
    plen = 2;
    prog[0] = 16'($urandom); prog[1] = 16'($urandom);
    load_prog(0, 1, 1'b0);
    plen = 1;
    prog[0] = 16'hEA87;
    load_prog(0, 0, 1'b0);

    // Asynchronous reset while the fill engine writes address 5
    plen = 2;
    prog[0] = 16'($urandom); prog[1] = 16'($urandom);
    wlog0.delete();
    wlog1.delete();
    pulse_start();
    send_words(0, 0, 1'b0);
    n = 0;
    while (!(imem_we[0] && imem_addr[0] == 15'd5) && n < 40) begin
      step();
      n++;
    end
    check("fill_addr5_seen", 32'(imem_addr[0]), 32'd5);
    reset = 1'b0;
    #1;
    check("arst_we", 32'(imem_we[0]), 32'd0);
    check("arst_cpu_reset", 32'(cpu_reset[0]), 32'd1);
    check("arst_busy", 32'(busy[0]), 32'd0);
    step();
    reset = 1'b1;
    step();
    n0 = wlog0.size();
    n1 = wlog1.size();
    repeat (6) step();
    check("arst_no_write0", 32'(wlog0.size()), 32'(n0));
    check("arst_no_write1", 32'(wlog1.size()), 32'(n1));
    check("arst_idle_ready", 32'(in_ready), 32'd0);
    check("arst_idle_cpu_reset", 32'(cpu_reset), 32'd3);
    check("arst_idle_done", 32'(done), 32'd0);
    check("arst_idle_wc", 32'(word_count[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
